// File: rtl/riscv_imm_pkg.sv
// Shared immediate-type coding, RISC-V major opcodes and the raw immediate layout helper.
package riscv_imm_pkg;

  typedef enum logic [2:0] {
    IMM_I       = 3'b000,
    IMM_S       = 3'b001,
    IMM_B       = 3'b010,
    IMM_J       = 3'b011,
    IMM_U       = 3'b100,
    IMM_Z       = 3'b101,
    IMM_NONE    = 3'b110,
    IMM_ILLEGAL = 3'b111
  } imm_type_t;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // Returns the immediate already sign-extended to 32 bits; callers widen from bit 31.
  function automatic logic [31:0] imm_layout(input logic [31:0] instr, input imm_type_t t);
    logic [31:0] r;
    r = '0;
    case (t)
      IMM_I:   r = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   r = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   r = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   r = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   r = {instr[31:12], 12'b0};
      IMM_Z:   r = {27'b0, instr[19:15]};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Immediate decoder: opcode -> type, extended immediate, illegal flag. IMM_ZICSR_EN adds the Z type.
// Combinational, no backpressure of its own.
module imm_decode
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_type_t       imm_type,
  output logic            illegal
);

  logic [31:0] raw;

  always_comb begin
    imm_type = IMM_ILLEGAL;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_type = IMM_I;
      OPC_STORE:                      imm_type = IMM_S;
      OPC_BRANCH:                     imm_type = IMM_B;
      OPC_JAL:                        imm_type = IMM_J;
      OPC_LUI, OPC_AUIPC:             imm_type = IMM_U;
      OPC_OP_IMM_32:                  imm_type = (XLEN == 64) ? IMM_I : IMM_ILLEGAL;
      OPC_OP:                         imm_type = IMM_NONE;
      OPC_OP_32:                      imm_type = (XLEN == 64) ? IMM_NONE : IMM_ILLEGAL;
`ifdef IMM_ZICSR_EN
      // funct3[2] selects the CSR-immediate forms, which carry zimm in rs1.
      OPC_SYSTEM:                     imm_type = instr[14] ? IMM_Z : IMM_I;
`else
      OPC_SYSTEM:                     imm_type = IMM_I;
`endif
      default:                        imm_type = IMM_ILLEGAL;
    endcase
  end

  assign raw     = imm_layout(instr, imm_type);
  assign imm     = XLEN'(signed'(raw));
  assign illegal = (imm_type == IMM_ILLEGAL);

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode + pc+imm, 2-entry skid buffer (IMM_ZICSR_EN enables Z).
// Latency 1 cycle; full throughput; in_ready = !skid valid, so it is a flop.
module imm_gen_stage
  import riscv_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output imm_type_t        out_type,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_pc,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  target;
    imm_type_t        typ;
    logic             illegal;
    logic [XLEN-1:0]  pc;
    logic [TAG_W-1:0] tag;
  } beat_t;

  logic [XLEN-1:0] dec_imm;
  imm_type_t       dec_type;
  logic            dec_illegal;
  beat_t           new_beat;
  beat_t           main_q, skid_q;
  logic            main_vld, skid_vld;
  logic            accept, drain;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr    (in_instr),
    .imm      (dec_imm),
    .imm_type (dec_type),
    .illegal  (dec_illegal)
  );

  always_comb begin
    new_beat         = '0;
    new_beat.imm     = dec_imm;
    new_beat.target  = in_pc + dec_imm;
    new_beat.typ     = dec_type;
    new_beat.illegal = dec_illegal;
    new_beat.pc      = in_pc;
    new_beat.tag     = in_tag;
  end

  assign in_ready = !skid_vld;
  assign accept   = in_valid && in_ready;
  assign drain    = main_vld && out_ready;

  // Skid only fills while main is held; it always empties into main on the next drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (drain) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        skid_vld <= 1'b0;
      end else if (accept) begin
        main_q   <= new_beat;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      if (!main_vld) begin
        main_q   <= new_beat;
        main_vld <= 1'b1;
      end else begin
        skid_q   <= new_beat;
        skid_vld <= 1'b1;
      end
    end
  end

  assign out_valid   = main_vld;
  assign out_imm     = main_q.imm;
  assign out_target  = main_q.target;
  assign out_type    = main_q.typ;
  assign out_illegal = main_q.illegal;
  assign out_pc      = main_q.pc;
  assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_stage;
  import riscv_imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic [3:0]  in_tag;

  logic        r32_in_ready, r32_out_valid, r32_ill;
  logic [31:0] r32_imm, r32_tgt, r32_pc;
  logic [2:0]  r32_type;
  logic [3:0]  r32_tag;
  logic        r64_in_ready, r64_out_valid, r64_ill;
  logic [63:0] r64_imm, r64_tgt, r64_pc;
  logic [2:0]  r64_type;
  logic [3:0]  r64_tag;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .in_tag(in_tag),
    .out_valid(r32_out_valid), .out_ready(out_ready), .out_imm(r32_imm),
    .out_target(r32_tgt), .out_type(r32_type), .out_illegal(r32_ill),
    .out_pc(r32_pc), .out_tag(r32_tag));

  imm_gen_stage #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r64_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(r64_out_valid), .out_ready(out_ready), .out_imm(r64_imm),
    .out_target(r64_tgt), .out_type(r64_type), .out_illegal(r64_ill),
    .out_pc(r64_pc), .out_tag(r64_tag));

  // Index 0 = XLEN 32 expectation (upper half zero), index 1 = XLEN 64.
  typedef struct {
    logic [63:0] imm [2];
    logic [63:0] tgt [2];
    int          typ [2];
    logic [63:0] pc;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cnt = 0;
  bit   held = 0;
  bit   rnd_ready = 0;
  logic [63:0] h32_imm, h32_tgt, h32_pc, h64_imm, h64_tgt;
  logic [3:0]  h32_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the ISA field definitions, using signed arithmetic.
  function automatic void ref_model(input logic [31:0] ins, input int xlen,
                                    output logic [63:0] imm, output int typ);
    longint s, v;
    s   = longint'(signed'(ins));
    v   = 0;
    typ = 7;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: typ = 0;
      7'h23: typ = 1;
      7'h63: typ = 2;
      7'h6F: typ = 3;
      7'h37, 7'h17: typ = 4;
      7'h1B: typ = (xlen == 64) ? 0 : 7;
      7'h33: typ = 6;
      7'h3B: typ = (xlen == 64) ? 6 : 7;
`ifdef IMM_ZICSR_EN
      7'h73: typ = ins[14] ? 5 : 0;
`else
      7'h73: typ = 0;
`endif
      default: typ = 7;
    endcase
    case (typ)
      0: v = s >>> 20;
      1: v = (s >>> 25) * 32 + longint'(ins[11:7]);
      2: v = (s >>> 31) * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
             + longint'(ins[11:8]) * 2;
      3: v = (s >>> 31) * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
             + longint'(ins[30:21]) * 2;
      4: v = (s >>> 12) * 4096;
      5: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    imm = (xlen == 32) ? {32'h0, v[31:0]} : v;
  endfunction

  function automatic exp_t mk_model(input logic [31:0] ins, input logic [63:0] pc,
                                    input logic [3:0] tag);
    exp_t e;
    logic [63:0] im;
    int t;
    logic [31:0] t32;
    ref_model(ins, 32, im, t);
    e.imm[0] = im; e.typ[0] = t;
    t32 = pc[31:0] + im[31:0];
    e.tgt[0] = {32'h0, t32};
    ref_model(ins, 64, im, t);
    e.imm[1] = im; e.typ[1] = t;
    e.tgt[1] = pc + im;
    e.pc = pc; e.tag = tag;
    return e;
  endfunction

  function automatic exp_t mk_const(input logic [63:0] imm, input logic [63:0] tgt, input int typ,
                                    input logic [63:0] pc, input logic [3:0] tag);
    exp_t e;
    e.imm[0] = {32'h0, imm[31:0]}; e.imm[1] = imm;
    e.tgt[0] = {32'h0, tgt[31:0]}; e.tgt[1] = tgt;
    e.typ[0] = typ; e.typ[1] = typ;
    e.pc = pc; e.tag = tag;
    return e;
  endfunction

  // Called at posedge+1; holds the beat until accepted and returns at posedge+1 with in_valid still high.
  task automatic send_e(input logic [31:0] ins, input logic [63:0] pc, input exp_t e);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; in_tag = e.tag;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (r32_in_ready) begin
        q.push_back(e);
        @(posedge clk); #1;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL accept_timeout: in_ready low for 200 cycles, required 1");
  endtask

  task automatic send_rand();
    logic [31:0] r, ins;
    logic [63:0] pc;
    logic [6:0]  ops [13];
    logic [6:0]  op;
    logic [3:0]  tag;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h1B, 7'h33, 7'h3B, 7'h73, 7'h7F};
    r  = $urandom;
    op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 12)];
    ins = {r[31:7], op};
    pc  = {32'($urandom), 32'($urandom)};
    tag = 4'($urandom);
    send_e(ins, pc, mk_model(ins, pc, tag));
  endtask

  // Monitor: occupancy model, stability while stalled, scoreboard pop on each output transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt  = 0;
      held = 0;
    end else begin
      bit acc, drn;
      exp_t e;
      chk("in_ready32", {63'h0, r32_in_ready}, {63'h0, cnt < 2});
      chk("in_ready64", {63'h0, r64_in_ready}, {63'h0, cnt < 2});
      chk("out_valid32", {63'h0, r32_out_valid}, {63'h0, cnt > 0});
      chk("out_valid64", {63'h0, r64_out_valid}, {63'h0, cnt > 0});
      if (held) begin
        chk("stable_imm32", {32'h0, r32_imm}, h32_imm);
        chk("stable_tgt32", {32'h0, r32_tgt}, h32_tgt);
        chk("stable_pc32", {32'h0, r32_pc}, h32_pc);
        chk("stable_tag32", {60'h0, r32_tag}, {60'h0, h32_tag});
        chk("stable_imm64", r64_imm, h64_imm);
        chk("stable_tgt64", r64_tgt, h64_tgt);
      end
      acc = in_valid && (cnt < 2);
      drn = (cnt > 0) && out_ready;
      if (drn) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_empty: output transfer with no expected beat queued");
        end else begin
          e = q.pop_front();
          chk("imm32", {32'h0, r32_imm}, e.imm[0]);
          chk("target32", {32'h0, r32_tgt}, e.tgt[0]);
          chk("type32", {61'h0, r32_type}, 64'(e.typ[0]));
          chk("illegal32", {63'h0, r32_ill}, {63'h0, e.typ[0] == 7});
          chk("pc32", {32'h0, r32_pc}, {32'h0, e.pc[31:0]});
          chk("tag32", {60'h0, r32_tag}, {60'h0, e.tag});
          chk("imm64", r64_imm, e.imm[1]);
          chk("target64", r64_tgt, e.tgt[1]);
          chk("type64", {61'h0, r64_type}, 64'(e.typ[1]));
          chk("illegal64", {63'h0, r64_ill}, {63'h0, e.typ[1] == 7});
          chk("pc64", r64_pc, e.pc);
          chk("tag64", {60'h0, r64_tag}, {60'h0, e.tag});
        end
      end
      held = (cnt > 0) && !out_ready;
      h32_imm = {32'h0, r32_imm}; h32_tgt = {32'h0, r32_tgt}; h32_pc = {32'h0, r32_pc};
      h32_tag = r32_tag; h64_imm = r64_imm; h64_tgt = r64_tgt;
      cnt = cnt + int'(acc) - int'(drn);
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h0; in_tag = 4'h0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready32", {63'h0, r32_in_ready}, 64'h1);
    chk("rst_out_valid32", {63'h0, r32_out_valid}, 64'h0);
    chk("rst_imm32", {32'h0, r32_imm}, 64'h0);
    chk("rst_in_ready64", {63'h0, r64_in_ready}, 64'h1);
    chk("rst_out_valid64", {63'h0, r64_out_valid}, 64'h0);
    chk("rst_imm64", r64_imm, 64'h0);
    chk("rst_target64", r64_tgt, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;

    // Streaming directed beats: addi -1, two branches, lui, jal wrap, illegal, csrrwi.
    send_e(32'hFFF00093, 64'h100, mk_const(64'hFFFFFFFFFFFFFFFF, 64'hFF, 0, 64'h100, 4'h1));
    send_e(32'hFE000EE3, 64'h200, mk_const(64'hFFFFFFFFFFFFFFFC, 64'h1FC, 2, 64'h200, 4'h2));
    send_e(32'h00000063, 64'h204, mk_const(64'h0, 64'h204, 2, 64'h204, 4'h3));
    send_e(32'h800000B7, 64'h0, mk_const(64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 4, 64'h0, 4'h4));
    send_e(32'h0080006F, 64'hFFFFFFFFFFFFFFFC, mk_const(64'h8, 64'h4, 3, 64'hFFFFFFFFFFFFFFFC, 4'h5));
    send_e(32'h0000007F, 64'h300, mk_const(64'h0, 64'h300, 7, 64'h300, 4'h6));
`ifdef IMM_ZICSR_EN
    send_e(32'h000FD073, 64'h400, mk_const(64'd31, 64'h41F, 5, 64'h400, 4'h7));
`else
    send_e(32'h000FD073, 64'h400, mk_const(64'h0, 64'h400, 0, 64'h400, 4'h7));
`endif
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Backpressure: three beats against a stalled output, then release.
    out_ready = 1'b0;
    fork
      begin
        repeat (3) send_rand();
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    // Reset with both entries full drops them.
    out_ready = 1'b0;
    repeat (2) send_rand();
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid32", {63'h0, r32_out_valid}, 64'h0);
    chk("midrst_in_ready32", {63'h0, r32_in_ready}, 64'h1);
    chk("midrst_out_valid64", {63'h0, r64_out_valid}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;

    // Random traffic with random output stalls and input gaps.
    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      send_rand();
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    rnd_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
